// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX pipeline register with operand forwarding, immediate select and load-use detection
module id_ex_operand_stage #(
  parameter int WIDTH     = 32,
  parameter int REG_BITS  = 5,
  parameter int CTRL_BITS = 4,
  parameter int IMM_BITS  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [0:REG_BITS-1]   id_rs1,
  input  logic [0:REG_BITS-1]   id_rs2,
  input  logic [0:WIDTH-1]      id_rs1_val,
  input  logic [0:WIDTH-1]      id_rs2_val,
  input  logic [0:IMM_BITS-1]   id_imm,
  input  logic                  id_use_imm,
  input  logic                  id_imm_signed,
  input  logic [0:CTRL_BITS-1]  id_ctrl,
  input  logic [0:REG_BITS-1]   id_rd,
  input  logic                  id_wb_en,
  input  logic                  id_is_load,
  input  logic [0:REG_BITS-1]   exmem_rd,
  input  logic                  exmem_wb_en,
  input  logic [0:WIDTH-1]      exmem_result,
  input  logic [0:REG_BITS-1]   memwb_rd,
  input  logic                  memwb_wb_en,
  input  logic [0:WIDTH-1]      memwb_result,
  input  logic                  stall_in,
  input  logic                  flush,
  output logic                  hazard_out,
  output logic                  ex_valid,
  output logic [0:WIDTH-1]      ex_a,
  output logic [0:WIDTH-1]      ex_b,
  output logic [0:CTRL_BITS-1]  ex_ctrl,
  output logic [0:REG_BITS-1]   ex_rd,
  output logic                  ex_wb_en,
  output logic                  ex_is_load
);

  // EX-slot state
  logic                 valid_q,      valid_d;
  logic [0:REG_BITS-1]  rs1_q,        rs1_d;
  logic [0:REG_BITS-1]  rs2_q,        rs2_d;
  logic [0:WIDTH-1]     a_q,          a_d;
  logic [0:WIDTH-1]     b_q,          b_d;
  logic [0:IMM_BITS-1]  imm_q,        imm_d;
  logic                 use_imm_q,    use_imm_d;
  logic                 imm_signed_q, imm_signed_d;
  logic [0:CTRL_BITS-1] ctrl_q,       ctrl_d;
  logic [0:REG_BITS-1]  rd_q,         rd_d;
  logic                 wb_en_q,      wb_en_d;
  logic                 is_load_q,    is_load_d;

  logic [0:WIDTH-1]     fwd_a;
  logic [0:WIDTH-1]     fwd_b;
  logic [0:WIDTH-1]     imm_ext;
  logic [0:WIDTH-1]     cap_a;
  logic [0:WIDTH-1]     cap_b;

  // Youngest producer wins; register 0 is never replaced by a forwarded value.
  function automatic logic [0:WIDTH-1] fwd(
    input logic [0:REG_BITS-1] r,
    input logic [0:WIDTH-1]    q,
    input logic [0:REG_BITS-1] xm_rd,
    input logic                xm_en,
    input logic [0:WIDTH-1]    xm_res,
    input logic [0:REG_BITS-1] mw_rd,
    input logic                mw_en,
    input logic [0:WIDTH-1]    mw_res
  );
    logic [0:WIDTH-1] v;
    v = q;
    if (r != '0) begin
      if (xm_en && (xm_rd == r)) begin
        v = xm_res;
      end else if (mw_en && (mw_rd == r)) begin
        v = mw_res;
      end
    end
    return v;
  endfunction

  // Operand forwarding from the held EX-slot values.
  always_comb begin
    fwd_a = fwd(rs1_q, a_q, exmem_rd, exmem_wb_en, exmem_result,
                memwb_rd, memwb_wb_en, memwb_result);
    fwd_b = fwd(rs2_q, b_q, exmem_rd, exmem_wb_en, exmem_result,
                memwb_rd, memwb_wb_en, memwb_result);
  end

  // Immediate extension; bit 0 is the sign bit in MSB-first numbering.
  always_comb begin
    imm_ext = {{(WIDTH-IMM_BITS){imm_signed_q & imm_q[0]}}, imm_q};
  end

  // Capture-time bypass so a value retiring from MEM/WB this cycle is not lost.
  always_comb begin
    cap_a = id_rs1_val;
    cap_b = id_rs2_val;
    if ((id_rs1 != '0) && memwb_wb_en && (memwb_rd == id_rs1)) begin
      cap_a = memwb_result;
    end
    if ((id_rs2 != '0) && memwb_wb_en && (memwb_rd == id_rs2)) begin
      cap_b = memwb_result;
    end
  end

  assign ex_valid   = valid_q;
  assign ex_a       = fwd_a;
  assign ex_b       = use_imm_q ? imm_ext : fwd_b;
  assign ex_ctrl    = ctrl_q;
  assign ex_rd      = rd_q;
  assign ex_wb_en   = wb_en_q & valid_q;
  assign ex_is_load = is_load_q & valid_q;

  assign hazard_out = id_valid & ex_valid & ex_is_load & (rd_q != '0) &
                      ((rd_q == id_rs1) | (~id_use_imm & (rd_q == id_rs2)));

  // Next-state selection: flush > stall (with operand refresh) > bubble > capture.
  always_comb begin
    valid_d      = valid_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    a_d          = a_q;
    b_d          = b_q;
    imm_d        = imm_q;
    use_imm_d    = use_imm_q;
    imm_signed_d = imm_signed_q;
    ctrl_d       = ctrl_q;
    rd_d         = rd_q;
    wb_en_d      = wb_en_q;
    is_load_d    = is_load_q;
    if (flush) begin
      valid_d   = 1'b0;
      wb_en_d   = 1'b0;
      is_load_d = 1'b0;
    end else if (stall_in) begin
      a_d = fwd_a;
      b_d = fwd_b;
    end else if (hazard_out) begin
      valid_d   = 1'b0;
      wb_en_d   = 1'b0;
      is_load_d = 1'b0;
    end else begin
      valid_d      = id_valid;
      rs1_d        = id_rs1;
      rs2_d        = id_rs2;
      a_d          = cap_a;
      b_d          = cap_b;
      imm_d        = id_imm;
      use_imm_d    = id_use_imm;
      imm_signed_d = id_imm_signed;
      ctrl_d       = id_ctrl;
      rd_d         = id_rd;
      wb_en_d      = id_valid & id_wb_en;
      is_load_d    = id_valid & id_is_load;
    end
  end

  // EX-slot register bank with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      imm_q        <= '0;
      use_imm_q    <= 1'b0;
      imm_signed_q <= 1'b0;
      ctrl_q       <= '0;
      rd_q         <= '0;
      wb_en_q      <= 1'b0;
      is_load_q    <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      a_q          <= a_d;
      b_q          <= b_d;
      imm_q        <= imm_d;
      use_imm_q    <= use_imm_d;
      imm_signed_q <= imm_signed_d;
      ctrl_q       <= ctrl_d;
      rd_q         <= rd_d;
      wb_en_q      <= wb_en_d;
      is_load_q    <= is_load_d;
    end
  end

endmodule
